edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
Multi-channel edge-event controller that shares one event-consumer port among N_CH input signals.
- Each channel runs its own dual-edge detector and holds pending rise/fall flags.
- A round-robin scheduler serialises pending events onto a single valid/ready output stream.
- Sits between raw status/button lines and the interrupt or event-logging logic.

Parameters:
- N_CH, 4, number of monitored input channels (2..16).
- CH_W, 2, channel-index width; must equal ceil(log2(N_CH)).
- SYNC, 1, 1 = two-flop synchroniser on each sig_in bit before detection; 0 = sig_in used directly (caller guarantees clk-synchronous inputs).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global detect enable.
- sig_in  in  N_CH  monitored signals.
- mask  in  N_CH  per-channel enable, 1 = channel active.
- evt_valid  out  1  event offered.
- evt_ready  in  1  consumer accepts event.
- evt_ch  out  CH_W  channel index of the offered event.
- evt_rise  out  1  offered event includes a rising edge.
- evt_fall  out  1  offered event includes a falling edge.
- overflow  out  N_CH  sticky per-channel lost-ordering flag.
- ovf_clr  in  1  clears all overflow bits.

Behaviour:
- Reset (async) values:
  - sync flops, prev, pending, overflow = 0.
  - evt_valid, evt_rise, evt_fall, evt_ch = 0.
  - state = IDLE; last_grant = N_CH-1, so channel 0 has first priority.
- Detection, per channel on the synchronised sample s:
  - rise = s & ~prev; fall = ~s & prev; prev <= s every cycle, regardless of en/mask.
  - An input already high when reset is released produces one rise event.
- Pending set:
  - A detected edge sets pend_rise/pend_fall only when en=1 and mask[i]=1.
  - mask[i]=0 also clears both pending bits of channel i; an event already latched on the output is unaffected.
- Overflow:
  - An edge arriving while channel i already has any pending bit set sets overflow[i].
  - The new edge's flag is ORed into the pending bits.
- Scheduler FSM:
  - IDLE: if any pending, pick the first pending channel at or after last_grant+1 (modulo N_CH). At that clock edge:
    - latch evt_ch, evt_rise, evt_fall from its pending bits;
    - clear those pending bits;
    - assert evt_valid; go to OFFER.
  - OFFER: evt_ch, evt_rise, evt_fall and evt_valid are held stable while evt_ready=0.
  - On evt_valid & evt_ready at a clock edge, last_grant <= evt_ch, then:
    - if any pending (round-robin from the new last_grant), latch the next event in the same edge and stay in OFFER, giving 1 event/cycle sustained throughput;
    - otherwise clear evt_valid, evt_rise, evt_fall and go to IDLE.
  - evt_ch retains its value in IDLE.
- Same-channel collision: if an edge on a channel coincides with that channel's pending bits being transferred to the output, the edge lands in the freshly cleared pending bits, with no overflow.
  - Edges arriving on a channel while its event is being offered go to pending, with no overflow.
- Latency, from the sig_in change (stable before clock edge k) to evt_valid=1 with the scheduler idle:
  - SYNC=0: pending set at edge k, evt_valid high after edge k+1.
  - SYNC=1: two cycles more (edge k+3).
- en=0: no new pending; already-pending events still drain.
- ovf_clr clears all overflow bits at the clock edge; a new overflow in the same cycle wins (bit stays set).
- Reset mid-offer: evt_valid drops immediately; all pending events are discarded.

Test Plan:
- SYNC=0, reset, single 0->1 on ch2 at edge k, ready=1 -> evt_valid=1 for one cycle after edge k+1 with ch=2, rise=1, fall=0. A later 1->0 gives ch=2, rise=0, fall=1.
- Simultaneous rises on ch0..ch3, ready=1 -> four back-to-back events, ch order 0,1,2,3. Repeat with all four again -> order 0,1,2,3 (last_grant=3). Prior grant of ch1 only then all four -> order 2,3,0,1.
- Backpressure: ready=0 for 5 cycles with an event on ch1 offered -> evt_valid, ch, and flags stable for all 5 cycles. A rise then fall on ch1 during the stall -> overflow[1]=1, next event ch=1 with rise=1 and fall=1.
- Edge on ch3 in the same cycle its prior event is transferred -> second ch3 event delivered, overflow[3]=0.
- mask[0]=0 with toggling ch0 -> no ch0 events. en=0 with toggling on all channels -> no new events. Re-enable with inputs static -> no spurious edge.
- Assert rst while evt_valid=1 -> evt_valid=0 before the next clock, overflow=0. sig_in held high through reset -> one rise event per high channel after release.
- ovf_clr asserted in the same cycle as a new overflow on ch2 -> overflow[2] remains 1, all others 0.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event stream between the edge arbiter and its consumer.
// The producer offers one channel event per valid/ready handshake.
interface edge_event_arbiter_if #(
    parameter int CH_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;
    logic            evt_fall;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        output evt_fall,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        input  evt_fall,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel dual-edge detector sharing one event stream.
// Each channel keeps pending rise/fall flags; a round-robin scheduler
// hands them out one event per handshake, back to back when busy.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2,
    parameter int SYNC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [N_CH-1:0]       mask,
    output logic [N_CH-1:0]       overflow,
    input  logic                  ovf_clr,
    edge_event_arbiter_if.master  evt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Channel N_CH-1 counts as the last grant so channel 0 wins first.
    localparam logic [CH_W-1:0] LAST_INIT = CH_W'(N_CH - 1);

    logic [N_CH-1:0] samp;
    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] det_rise;
    logic [N_CH-1:0] det_fall;
    logic [N_CH-1:0] new_rise;
    logic [N_CH-1:0] new_fall;

    logic [N_CH-1:0] pend_rise;
    logic [N_CH-1:0] pend_fall;
    logic [N_CH-1:0] pend_any;
    logic [N_CH-1:0] kept_rise;
    logic [N_CH-1:0] kept_fall;
    logic [N_CH-1:0] ovf_set;

    state_t          state;
    state_t          state_n;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] last_grant_n;
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ch_n;
    logic            rise_q;
    logic            rise_n;
    logic            fall_q;
    logic            fall_n;

    logic [CH_W-1:0] pick_base;
    logic [CH_W-1:0] pick_idx;
    logic            pick_found;
    logic            take;
    logic [N_CH-1:0] grant_oh;

    generate
        if (SYNC != 0) begin : g_sync
            logic [N_CH-1:0] sync_a;
            logic [N_CH-1:0] sync_b;

            // Two-flop synchroniser for asynchronous status/button lines.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_a <= '0;
                    sync_b <= '0;
                end else begin
                    sync_a <= sig_in;
                    sync_b <= sync_a;
                end
            end

            assign samp = sync_b;
        end else begin : g_nosync
            assign samp = sig_in;
        end
    endgenerate

    // Previous sample tracks the input every cycle so re-enabling never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= samp;
        end
    end

    assign det_rise = samp & ~prev;
    assign det_fall = ~samp & prev;
    assign new_rise = det_rise & mask & {N_CH{en}};
    assign new_fall = det_fall & mask & {N_CH{en}};

    // Masked channels are never eligible, their flags are dropped this cycle.
    assign pend_any  = (pend_rise | pend_fall) & mask;

    // What survives of the pending flags after a transfer and masking, before new edges.
    assign kept_rise = pend_rise & ~grant_oh & mask;
    assign kept_fall = pend_fall & ~grant_oh & mask;

    // A new edge only overflows if it meets flags that were not just handed out.
    assign ovf_set   = (new_rise | new_fall) & (kept_rise | kept_fall);

    // Pending flags and sticky overflow; a same-cycle overflow beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rise <= '0;
            pend_fall <= '0;
            overflow  <= '0;
        end else begin
            pend_rise <= kept_rise | new_rise;
            pend_fall <= kept_fall | new_fall;
            overflow  <= (ovf_clr ? '0 : overflow) | ovf_set;
        end
    end

    // Round-robin search starts just after the previous grant; during a
    // handshake the channel being accepted becomes that previous grant.
    assign pick_base = (state == OFFER) ? ch_q : last_grant;

    // Two passes: channels above the base first, then wrap to the rest.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!pick_found && pend_any[i] && (i > int'(pick_base))) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!pick_found && pend_any[i] && (i <= int'(pick_base))) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(i);
            end
        end
    end

    // Scheduler next state: latch a new event from idle or straight after a handshake.
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        ch_n         = ch_q;
        rise_n       = rise_q;
        fall_n       = fall_q;
        take         = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    take    = 1'b1;
                    ch_n    = pick_idx;
                    rise_n  = pend_rise[pick_idx];
                    fall_n  = pend_fall[pick_idx];
                    state_n = OFFER;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    last_grant_n = ch_q;
                    if (pick_found) begin
                        take   = 1'b1;
                        ch_n   = pick_idx;
                        rise_n = pend_rise[pick_idx];
                        fall_n = pend_fall[pick_idx];
                    end else begin
                        rise_n  = 1'b0;
                        fall_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // One-hot of the channel whose flags move to the output this cycle.
    always_comb begin
        grant_oh = '0;
        if (take) begin
            grant_oh[pick_idx] = 1'b1;
        end
    end

    // Scheduler registers; the offered event stays frozen until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LAST_INIT;
            ch_q       <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            ch_q       <= ch_n;
            rise_q     <= rise_n;
            fall_q     <= fall_n;
        end
    end

    assign evt.evt_valid = (state == OFFER);
    assign evt.evt_ch    = ch_q;
    assign evt.evt_rise  = rise_q;
    assign evt.evt_fall  = fall_q;

endmodule
